instr_fetch: RTL and testbench

Instruction fetch and sequencing unit feeding the 20-bit `instruction` bus of `simple_cpu`. A host loads a program into a 2^PC_BITS-word internal instruction buffer over a valid/ready handshake. On a `run` command the unit issues the program to the CPU one word per cycle, inserting NOPs while stalled, idle or finished. It is the producer end of the CPU's instruction interface.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/instr_mem.sv | 24 ++
 rtl/instr_fetch.sv | 142 ++++++++++++++
 tb/tb_instr_fetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    localparam int INSTR_WIDTH_DEF = 20;
    localparam int PC_BITS_DEF     = 5;

    localparam logic [INSTR_WIDTH_DEF-1:0] NOP_INSTR = 20'h00000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } fetch_state_e;

endpackage

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - program buffer, one synchronous write port and one combinational read port
module instr_mem #(
    parameter int WIDTH     = 20,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - loads a program from the host and issues it to the CPU one word per cycle
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int PC_BITS     = PC_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   load_valid,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   load_last,
    output logic                   load_ready,
    input  logic                   run,
    input  logic                   stall,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   done
);

    localparam logic [INSTR_WIDTH-1:0] NOP      = INSTR_WIDTH'(NOP_INSTR);
    localparam logic [PC_BITS:0]       LAST_LEN = {1'b0, {PC_BITS{1'b1}}};

    fetch_state_e            state_q, state_d;
    logic [PC_BITS-1:0]      wptr_q, wptr_d;
    logic [PC_BITS:0]        len_q, len_d;
    logic [PC_BITS-1:0]      pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic                    wr_en;
    logic [INSTR_WIDTH-1:0]  rd_data;

    // len_q reaching 2^PC_BITS is the full flag; the MSB alone encodes it
    assign load_ready  = (state_q == S_LOAD) && !len_q[PC_BITS];
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign done        = done_q;

    instr_mem #(
        .WIDTH     (INSTR_WIDTH),
        .ADDR_BITS (PC_BITS)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr_q),
        .wdata (load_data),
        .raddr (pc_q),
        .rdata (rd_data)
    );

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        len_d   = len_q;
        pc_d    = pc_q;
        instr_d = NOP;
        valid_d = 1'b0;
        done_d  = 1'b0;
        wr_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                    len_d   = '0;
                end else if (run && (len_q != '0)) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_LOAD: begin
                if (load_start) begin
                    wptr_d = '0;
                    len_d  = '0;
                end else if (load_valid && load_ready) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    len_d  = len_q + 1'b1;
                    if (load_last || (len_q == LAST_LEN)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                    len_d   = '0;
                end else if (!stall) begin
                    // A stalled edge emits a NOP and keeps pc, so no word is ever repeated
                    instr_d = rd_data;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 1'b1;
                    if (({1'b0, pc_q} + 1'b1) == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                    len_d   = '0;
                end else if (run) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            len_q   <= '0;
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            len_q   <= len_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [19:0] load_data = 20'h0;
    logic        load_last = 1'b0;
    logic        run = 1'b0;
    logic        stall = 1'b0;
    logic        load_ready;
    logic [19:0] instruction;
    logic        instr_valid;
    logic [4:0]  pc;
    logic        done;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [19:0] prog [32];
    logic [27:0] exp_v;
    wire  [27:0] obs = {instruction, instr_valid, pc, done, load_ready};

    instr_fetch #(
        .INSTR_WIDTH (20),
        .PC_BITS     (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .run         (run),
        .stall       (stall),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_basic();
        prog[0] = 20'h10001;
        prog[1] = 20'h20002;
        prog[2] = 20'h30003;
    endtask

    task automatic feed_words(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = use_last && (i == n - 1);
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic load_prog(input int n);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        feed_words(n, 1'b1);
    endtask

    task automatic pulse_run();
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        exp_v = 28'h0;
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL reset_state got %h exp %h", obs, exp_v); end
        rst = 1'b1;
    endtask

    task automatic test_ignored();
        pulse_run();
        for (int i = 0; i < 2; i++) begin
            exp_v = 28'h0;
            n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL run_len0_c%0d got %h exp %h", i, obs, exp_v); end
            step();
        end
        load_start = 1'b1;
        run        = 1'b1;
        step();
        load_start = 1'b0;
        run        = 1'b0;
        exp_v = {20'h0, 1'b0, 5'd0, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL start_beats_run got %h exp %h", obs, exp_v); end
        set_basic();
        feed_words(3, 1'b1);
        exp_v = 28'h0;
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL load_last_exit got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_basic();
        pulse_run();
        exp_v = 28'h0;
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL basic_e0 got %h exp %h", obs, exp_v); end
        for (int k = 0; k < 3; k++) begin
            step();
            exp_v = {prog[k], 1'b1, 5'(k + 1), 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL basic_w%0d got %h exp %h", k, obs, exp_v); end
        end
        step();
        exp_v = {20'h0, 1'b0, 5'd3, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL basic_done got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_stall();
        pulse_run();
        exp_v = 28'h0;
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL stall_rerun_e0 got %h exp %h", obs, exp_v); end
        step();
        exp_v = {20'h10001, 1'b1, 5'd1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL stall_w0 got %h exp %h", obs, exp_v); end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            exp_v = {20'h0, 1'b0, 5'd1, 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL stall_nop%0d got %h exp %h", i, obs, exp_v); end
        end
        stall = 1'b0;
        for (int k = 1; k < 3; k++) begin
            step();
            exp_v = {prog[k], 1'b1, 5'(k + 1), 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL stall_w%0d got %h exp %h", k, obs, exp_v); end
        end
        step();
        exp_v = {20'h0, 1'b0, 5'd3, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL stall_done got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_abort();
        pulse_run();
        step();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        exp_v = {20'h0, 1'b0, 5'd1, 1'b0, 1'b1};
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL abort_to_load got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 32; i++) prog[i] = 20'(i + 1);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (load_ready !== 1'b1) begin n_errors++; $display("FAIL full_ready_w%0d got %b exp 1", i, load_ready); end
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = 1'b0;
            step();
        end
        load_valid = 1'b0;
        n_checks++;
        if ({instr_valid, done, load_ready} !== 3'b000) begin
            n_errors++; $display("FAIL full_ready_drop got %b exp 000", {instr_valid, done, load_ready});
        end
        pulse_run();
        exp_v = 28'h0;
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL full_e0 got %h exp %h", obs, exp_v); end
        for (int k = 0; k < 32; k++) begin
            step();
            exp_v = {prog[k], 1'b1, 5'((k + 1) % 32), 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL full_w%0d got %h exp %h", k, obs, exp_v); end
        end
        step();
        exp_v = {20'h0, 1'b0, 5'd0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL full_done got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_rerun();
        set_basic();
        load_prog(3);
        pulse_run();
        step();
        #2;
        rst = 1'b0;
        #1;
        exp_v = 28'h0;
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL reset_mid_run got %h exp %h", obs, exp_v); end
        #2;
        rst = 1'b1;
        pulse_run();
        for (int i = 0; i < 2; i++) begin
            exp_v = 28'h0;
            n_checks++;
            if (obs !== exp_v) begin n_errors++; $display("FAIL run_after_reset_c%0d got %h exp %h", i, obs, exp_v); end
            step();
        end
        load_prog(3);
        pulse_run();
        for (int k = 0; k < 4; k++) step();
        exp_v = {20'h0, 1'b0, 5'd3, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL reload_done got %h exp %h", obs, exp_v); end
        pulse_run();
        step();
        exp_v = {20'h10001, 1'b1, 5'd1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL rerun_w0 got %h exp %h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_ignored();
        test_basic();
        test_stall();
        test_abort();
        test_full();
        test_rerun();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
